// File: rtl/mux_arb_feeder.sv
// Four-channel buffered front-end for the 4:1 nibble mux: one holding slot per channel,
// arbitrated into a registered valid/ready output. Define FIXED_PRIO_EN for fixed priority.
module mux_arb_feeder #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  input  logic [3:0]       in_valid,
  output logic [3:0]       in_ready,
  output logic [1:0]       sel,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  input  logic             out_ready
);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t           state_q, state_d;
  logic [3:0]       held_q, held_d;
  logic [WIDTH-1:0] slot_q [4];
  logic [WIDTH-1:0] slot_d [4];
  logic [1:0]       sel_q, sel_d;
  logic [WIDTH-1:0] out_q, out_d;
`ifndef FIXED_PRIO_EN
  logic [1:0]       rr_ptr_q, rr_ptr_d;
  logic [1:0]       search_idx;
`endif

  logic [WIDTH-1:0] ch_data [4];
  logic             load_ok;
  logic             grant_valid;
  logic [1:0]       grant_idx;
  logic             grant_fire;
  logic [3:0]       grant_oh;
  logic [3:0]       accept;

  assign ch_data[0] = a;
  assign ch_data[1] = b;
  assign ch_data[2] = c;
  assign ch_data[3] = d;

  // Arbiter looks only at held slots; descending scan so the highest-priority hit wins.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = 2'd0;
`ifdef FIXED_PRIO_EN
    for (int k = 3; k >= 0; k--) begin
      if (held_q[k]) begin
        grant_valid = 1'b1;
        grant_idx   = 2'(k);
      end
    end
`else
    search_idx = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      search_idx = rr_ptr_q + 2'(k);
      if (held_q[search_idx]) begin
        grant_valid = 1'b1;
        grant_idx   = search_idx;
      end
    end
`endif
  end

  assign load_ok    = (state_q == EMPTY) || out_ready;
  assign grant_fire = load_ok && grant_valid;
  assign grant_oh   = grant_fire ? (4'b0001 << grant_idx) : 4'b0000;
  assign in_ready   = ~held_q | grant_oh;
  assign accept     = in_valid & in_ready;

  always_comb begin
    held_d  = (held_q & ~grant_oh) | accept;
    state_d = state_q;
    sel_d   = sel_q;
    out_d   = out_q;
`ifndef FIXED_PRIO_EN
    rr_ptr_d = rr_ptr_q;
`endif
    for (int i = 0; i < 4; i++) begin
      slot_d[i] = accept[i] ? ch_data[i] : slot_q[i];
    end
    // A refill of the granted slot lands on the same edge the old contents leave.
    if (load_ok) begin
      if (grant_valid) begin
        state_d = FULL;
        sel_d   = grant_idx;
        out_d   = slot_q[grant_idx];
`ifndef FIXED_PRIO_EN
        rr_ptr_d = grant_idx + 2'd1;
`endif
      end else begin
        state_d = EMPTY;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      held_q  <= 4'b0000;
      sel_q   <= 2'd0;
      out_q   <= '0;
`ifndef FIXED_PRIO_EN
      rr_ptr_q <= 2'd0;
`endif
      for (int i = 0; i < 4; i++) begin
        slot_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      held_q  <= held_d;
      sel_q   <= sel_d;
      out_q   <= out_d;
`ifndef FIXED_PRIO_EN
      rr_ptr_q <= rr_ptr_d;
`endif
      for (int i = 0; i < 4; i++) begin
        slot_q[i] <= slot_d[i];
      end
    end
  end

  assign sel       = sel_q;
  assign out       = out_q;
  assign out_valid = (state_q == FULL);

endmodule

// File: tb/tb_mux_arb_feeder.sv
// Directed self-checking bench for mux_arb_feeder; expectations follow FIXED_PRIO_EN
// when that macro is defined for the build.
module tb_mux_arb_feeder;

  logic       clk;
  logic       rst_n;
  logic [3:0] a, b, c, d;
  logic [3:0] in_valid;
  logic [3:0] in_ready;
  logic [1:0] sel;
  logic [3:0] out;
  logic       out_valid;
  logic       out_ready;

  int testCount;
  int failCount;

  mux_arb_feeder #(.WIDTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a         (a),
    .b         (b),
    .c         (c),
    .d         (d),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sel       (sel),
    .out       (out),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    testCount++;
    if (got !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] v, input logic [3:0] da, input logic [3:0] db,
                               input logic [3:0] dc, input logic [3:0] dd, input logic rdy);
    in_valid  = v;
    a         = da;
    b         = db;
    c         = dc;
    d         = dd;
    out_ready = rdy;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkBeat(input string tag, input logic v, input logic [1:0] s, input logic [3:0] o);
    checkOutput({tag, "_valid"}, 32'(out_valid), 32'(v));
    if (v) begin
      checkOutput({tag, "_sel"}, 32'(sel), 32'(s));
      checkOutput({tag, "_out"}, 32'(out), 32'(o));
    end
  endtask

  logic [1:0] expSel [6];
  logic [3:0] expOut [6];
  logic [1:0] frozenSel;
  logic [3:0] frozenOut;

  initial begin
    testCount = 0;
    failCount = 0;

    // Reset with every channel trying to load
    rst_n = 1'b0;
    applyStimulus(4'hF, 4'h9, 4'h9, 4'h9, 4'h9, 1'b0);
    tick();
    tick();
    checkBeat("reset", 1'b0, 2'd0, 4'h0);
    checkOutput("reset_sel", 32'(sel), 32'd0);
    checkOutput("reset_out", 32'(out), 32'd0);
    applyStimulus(4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b1);
    rst_n = 1'b1;
    #1;
    checkOutput("release_in_ready", 32'(in_ready), 32'hF);
    tick();
    checkBeat("release_no_slot", 1'b0, 2'd0, 4'h0);

    // Fairness: all four loaded together, drained in index order
    applyStimulus(4'hF, 4'h1, 4'h2, 4'h3, 4'h4, 1'b1);
    tick();
    applyStimulus(4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b1);
    checkBeat("fair_latency", 1'b0, 2'd0, 4'h0);
    for (int i = 0; i < 4; i++) begin
      tick();
      checkBeat($sformatf("fair%0d", i), 1'b1, 2'(i), 4'(i + 1));
    end
    tick();
    checkBeat("fair_drained", 1'b0, 2'd0, 4'h0);

    // Single channel with consumer stall
    applyStimulus(4'b0001, 4'h5, 4'h0, 4'h0, 4'h0, 1'b0);
    tick();
    applyStimulus(4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
    checkBeat("single_latency", 1'b0, 2'd0, 4'h0);
    tick();
    checkBeat("single_out", 1'b1, 2'd0, 4'h5);
    tick();
    tick();
    checkBeat("single_hold", 1'b1, 2'd0, 4'h5);
    applyStimulus(4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b1);
    tick();
    checkBeat("single_drain", 1'b0, 2'd0, 4'h0);

    // Wrap: a lone ch2 grant leaves the pointer at 3, then ch0/ch2/ch3 compete
    applyStimulus(4'b0100, 4'h0, 4'h0, 4'h7, 4'h0, 1'b1);
    tick();
    applyStimulus(4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b1);
    tick();
    checkBeat("wrap_pre", 1'b1, 2'd2, 4'h7);
    applyStimulus(4'b1101, 4'h8, 4'h0, 4'h9, 4'h6, 1'b1);
    tick();
    applyStimulus(4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b1);
`ifdef FIXED_PRIO_EN
    expSel[0] = 2'd0; expOut[0] = 4'h8;
    expSel[1] = 2'd2; expOut[1] = 4'h9;
    expSel[2] = 2'd3; expOut[2] = 4'h6;
`else
    expSel[0] = 2'd3; expOut[0] = 4'h6;
    expSel[1] = 2'd0; expOut[1] = 4'h8;
    expSel[2] = 2'd2; expOut[2] = 4'h9;
`endif
    for (int i = 0; i < 3; i++) begin
      tick();
      checkBeat($sformatf("wrap%0d", i), 1'b1, expSel[i], expOut[i]);
    end
    tick();
    checkBeat("wrap_drained", 1'b0, 2'd0, 4'h0);

    // Continuous requests on every channel from a fresh reset
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    applyStimulus(4'hF, 4'h1, 4'h2, 4'h3, 4'h4, 1'b1);
    tick();
    for (int i = 0; i < 6; i++) begin
`ifdef FIXED_PRIO_EN
      expSel[i] = 2'd0;
`else
      expSel[i] = 2'(i % 4);
`endif
      expOut[i] = 4'(expSel[i] + 2'd1);
    end
    for (int i = 0; i < 6; i++) begin
      tick();
      checkBeat($sformatf("cont%0d", i), 1'b1, expSel[i], expOut[i]);
    end

    // Backpressure with every slot full: nothing moves, nothing is accepted
    frozenSel = sel;
    frozenOut = out;
    applyStimulus(4'hF, 4'hA, 4'hB, 4'hC, 4'hD, 1'b0);
    checkOutput("bp_in_ready", 32'(in_ready), 32'h0);
    for (int i = 0; i < 5; i++) begin
      tick();
      checkBeat($sformatf("bp_hold%0d", i), 1'b1, frozenSel, frozenOut);
      checkOutput($sformatf("bp_in_ready%0d", i), 32'(in_ready), 32'h0);
    end
    applyStimulus(4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b1);
`ifdef FIXED_PRIO_EN
    for (int i = 0; i < 4; i++) expSel[i] = 2'(i);
`else
    for (int i = 0; i < 4; i++) expSel[i] = 2'((i + 2) % 4);
`endif
    for (int i = 0; i < 4; i++) begin
      tick();
      checkBeat($sformatf("bp_release%0d", i), 1'b1, expSel[i], 4'(expSel[i] + 2'd1));
    end
    tick();
    checkBeat("bp_drained", 1'b0, 2'd0, 4'h0);

    // Reset while output is valid and slots are full
    applyStimulus(4'hF, 4'h1, 4'h2, 4'h3, 4'h4, 1'b0);
    tick();
    tick();
    tick();
    checkOutput("mid_pre_valid", 32'(out_valid), 32'd1);
    checkOutput("mid_pre_in_ready", 32'(in_ready), 32'h0);
    rst_n = 1'b0;
    #1;
    checkOutput("mid_valid", 32'(out_valid), 32'd0);
    checkOutput("mid_sel", 32'(sel), 32'd0);
    checkOutput("mid_out", 32'(out), 32'd0);
    checkOutput("mid_in_ready", 32'(in_ready), 32'hF);
    applyStimulus(4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b1);
    rst_n = 1'b1;
    tick();
    checkBeat("mid_no_stale", 1'b0, 2'd0, 4'h0);
    applyStimulus(4'hF, 4'hE, 4'hD, 4'hC, 4'hB, 1'b1);
    tick();
    applyStimulus(4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b1);
    tick();
    checkBeat("mid_first", 1'b1, 2'd0, 4'hE);
    tick();
    checkBeat("mid_second", 1'b1, 2'd1, 4'hD);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
